// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and sizing helpers for serial_adder_n
package serial_adder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Number of digits (clock cycles) needed for one operation.
    function automatic int calc_n(input int width, input int digit);
        return width / digit;
    endfunction

    // Digit counter width; at least one bit so N=1 still has a legal register.
    function automatic int calc_cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_adder_n_fa_digit.sv
// rtl/serial_adder_n_fa_digit.sv - DIGIT-bit ripple of full adders (c_msb only with SERIAL_ADDER_OVF_EN)
module fa_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             c_msb
`endif
);

    logic [DIGIT:0] w_c;

    assign w_c[0] = cin;

    genvar i;
    for (i = 0; i < DIGIT; i++) begin : g_fa
        assign s[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[DIGIT];

`ifdef SERIAL_ADDER_OVF_EN
    // Carry into the top bit; XOR with cout gives signed overflow.
    assign c_msb = w_c[DIGIT-1];
`endif

endmodule

// File: rtl/serial_adder_n.sv
// rtl/serial_adder_n.sv - digit-serial add/subtract with start/busy/done handshake (option: SERIAL_ADDER_OVF_EN)
module serial_adder_n
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic [WIDTH-1:0] S,
    output logic             COUT,
    output logic             OVF,
    output logic             BUSY,
    output logic             DONE
);

    localparam int             N        = calc_n(WIDTH, DIGIT);
    localparam int             CW       = calc_cnt_w(N);
    localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);

    state_t           r_state;
    // r_a holds operand A; as its low digit is consumed the sum digit enters
    // at the top, so after N shifts it holds the complete result.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;

    logic [DIGIT-1:0] w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_a_next;
    logic             w_accept;
    logic             w_last;

    assign w_accept = START && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last   = (r_state == ST_RUN) && (r_cnt == CNT_LAST);

`ifdef SERIAL_ADDER_OVF_EN
    logic w_cmsb;
    logic r_ovf;

    fa_digit #(.DIGIT(DIGIT)) u_fa (
        .a     (r_a[DIGIT-1:0]),
        .b     (r_b[DIGIT-1:0]),
        .cin   (r_carry),
        .s     (w_sum),
        .cout  (w_cout),
        .c_msb (w_cmsb)
    );

    // Overflow flag is captured only at completion, alongside S and COUT.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= w_cmsb ^ w_cout;
        end
    end

    assign OVF = r_ovf;
`else
    fa_digit #(.DIGIT(DIGIT)) u_fa (
        .a    (r_a[DIGIT-1:0]),
        .b    (r_b[DIGIT-1:0]),
        .cin  (r_carry),
        .s    (w_sum),
        .cout (w_cout)
    );

    assign OVF = 1'b0;
`endif

    // With a single digit the whole register is replaced by the sum.
    if (N == 1) begin : g_one_digit
        assign w_a_next = w_sum;
    end else begin : g_multi_digit
        assign w_a_next = {w_sum, r_a[WIDTH-1:DIGIT]};
    end

    // Control FSM plus operand/carry datapath and result capture.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        // Subtract is A + ~B + ~borrow, so fold SUB into B and the carry.
                        r_a     <= A;
                        r_b     <= SUB ? ~B : B;
                        r_carry <= CIN ^ SUB;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_a     <= w_a_next;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_cout;
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_s     <= w_a_next;
                        r_cout  <= w_cout;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign S    = r_s;
    assign COUT = r_cout;
    assign BUSY = (r_state == ST_RUN);
    assign DONE = (r_state == ST_DONE);

endmodule

// File: tb/tb_serial_adder_n.sv
// tb/tb_serial_adder_n.sv - scoreboard bench for serial_adder_n at DIGIT 1, 4 and 16
module tb_serial_adder_n;

`ifdef SERIAL_ADDER_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
        int          acc;
        int          n;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        st [3];
    logic        sub;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;

    logic [15:0] s1, s4, s16;
    logic        c1, c4, c16, o1, o4, o16, bz1, bz4, bz16, d1, d4, d16;

    logic [15:0] m_s    [3];
    logic        m_cout [3];
    logic        m_ovf  [3];
    logic        m_busy [3];
    logic        m_done [3];

    exp_t q [3][$];
    int   n_of [3];
    int   bcnt [3];
    int   cyc;
    int   tests;
    int   fails;
    exp_t m_e;

    serial_adder_n #(.WIDTH(16), .DIGIT(1)) dut1 (
        .CLK(clk), .RST_N(rst_n), .START(st[0]), .SUB(sub), .A(a), .B(b), .CIN(cin),
        .S(s1), .COUT(c1), .OVF(o1), .BUSY(bz1), .DONE(d1));
    serial_adder_n #(.WIDTH(16), .DIGIT(4)) dut4 (
        .CLK(clk), .RST_N(rst_n), .START(st[1]), .SUB(sub), .A(a), .B(b), .CIN(cin),
        .S(s4), .COUT(c4), .OVF(o4), .BUSY(bz4), .DONE(d4));
    serial_adder_n #(.WIDTH(16), .DIGIT(16)) dut16 (
        .CLK(clk), .RST_N(rst_n), .START(st[2]), .SUB(sub), .A(a), .B(b), .CIN(cin),
        .S(s16), .COUT(c16), .OVF(o16), .BUSY(bz16), .DONE(d16));

    assign m_s[0] = s1;   assign m_cout[0] = c1;  assign m_ovf[0] = o1;  assign m_busy[0] = bz1;  assign m_done[0] = d1;
    assign m_s[1] = s4;   assign m_cout[1] = c4;  assign m_ovf[1] = o4;  assign m_busy[1] = bz4;  assign m_done[1] = d4;
    assign m_s[2] = s16;  assign m_cout[2] = c16; assign m_ovf[2] = o16; assign m_busy[2] = bz16; assign m_done[2] = d16;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents DONE.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                bcnt[i] = 0;
            end else begin
                if (m_busy[i]) bcnt[i] = bcnt[i] + 1;
                if (m_done[i]) begin
                    if (q[i].size() == 0) begin
                        chk($sformatf("unexpected_done_dut%0d", i), 32'd1, 32'd0);
                    end else begin
                        m_e = q[i].pop_front();
                        chk($sformatf("s_dut%0d", i),       32'(m_s[i]),    32'(m_e.s));
                        chk($sformatf("cout_dut%0d", i),    32'(m_cout[i]), 32'(m_e.cout));
                        chk($sformatf("ovf_dut%0d", i),     32'(m_ovf[i]),  32'(m_e.ovf));
                        chk($sformatf("latency_dut%0d", i), 32'(cyc - m_e.acc), 32'(m_e.n));
                        chk($sformatf("busy_len_dut%0d", i), 32'(bcnt[i]),  32'(m_e.n));
                    end
                    bcnt[i] = 0;
                end
            end
        end
    end

    function automatic exp_t mk(input logic [15:0] es, input logic ec, input logic eo,
                                input int acc, input int n);
        exp_t e;
        e.s = es; e.cout = ec; e.ovf = eo & OVF_EN; e.acc = acc; e.n = n;
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input int id, input logic [15:0] va, input logic [15:0] vb,
                         input logic vsub, input logic vcin,
                         input logic [15:0] es, input logic ec, input logic eo);
        a = va; b = vb; sub = vsub; cin = vcin;
        st[id] = 1'b1;
        q[id].push_back(mk(es, ec, eo, cyc + 1, n_of[id]));
        @(negedge clk);
        st[id] = 1'b0;
    endtask

    task automatic wait_drain(input int id);
        int k;
        k = 0;
        while (q[id].size() != 0 && k < 200) begin
            @(negedge clk);
            k = k + 1;
        end
        if (q[id].size() != 0) begin
            chk($sformatf("timeout_dut%0d", id), 32'(q[id].size()), 32'd0);
            q[id].delete();
        end
    endtask

    int c0;

    initial begin
        tests = 0; fails = 0;
        n_of[0] = 16; n_of[1] = 4; n_of[2] = 1;
        rst_n = 1'b0;
        st[0] = 1'b0; st[1] = 1'b0; st[2] = 1'b0;
        a = 16'h0; b = 16'h0; sub = 1'b0; cin = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_s_dut%0d", i),    32'(m_s[i]),    32'd0);
            chk($sformatf("rst_cout_dut%0d", i), 32'(m_cout[i]), 32'd0);
            chk($sformatf("rst_ovf_dut%0d", i),  32'(m_ovf[i]),  32'd0);
            chk($sformatf("rst_busy_dut%0d", i), 32'(m_busy[i]), 32'd0);
            chk($sformatf("rst_done_dut%0d", i), 32'(m_done[i]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        issue(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0); wait_drain(0);
        issue(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); wait_drain(0);
        issue(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1); wait_drain(0);
        issue(0, 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0); wait_drain(0);
        issue(0, 16'h0009, 16'h0003, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0); wait_drain(0);
        issue(0, 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1); wait_drain(0);

        // START pulse inside RUN must be ignored: exactly one DONE.
        issue(0, 16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        wait_drain(0);
        repeat (20) @(negedge clk);

        // START held across DONE: second op accepted at the DONE edge, inputs
        // changed mid-run for the second op without disturbing the first.
        c0 = cyc;
        a = 16'h00FF; b = 16'h0001; sub = 1'b0; cin = 1'b0;
        st[0] = 1'b1;
        q[0].push_back(mk(16'h0100, 1'b0, 1'b0, c0 + 1, 16));
        while (cyc < c0 + 5) @(negedge clk);
        a = 16'h7FFF; b = 16'h0001;
        q[0].push_back(mk(16'h8000, 1'b0, 1'b1, c0 + 18, 16));
        while (cyc < c0 + 18) @(negedge clk);
        st[0] = 1'b0;
        wait_drain(0);

        // Reset in the 8th RUN cycle aborts: outputs cleared, no DONE afterwards.
        a = 16'hFFFF; b = 16'h0001; sub = 1'b0; cin = 1'b0;
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(bz1), 32'd0);
        chk("abort_s",    32'(s1),  32'd0);
        chk("abort_cout", 32'(c1),  32'd0);
        chk("abort_ovf",  32'(o1),  32'd0);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);

        issue(1, 16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0); wait_drain(1);
        issue(1, 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1); wait_drain(1);
        issue(2, 16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0); wait_drain(2);
        issue(2, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0); wait_drain(2);
        issue(2, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1); wait_drain(2);
        repeat (5) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            chk($sformatf("leftover_dut%0d", i), 32'(q[i].size()), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
